cdb_arbiter: RTL and testbench

//  Responder end of the execution-unit -> CDB handshake. Collects completed results

---
 rtl/rv32i_types.sv | 17 +
 rtl/cdb_arbiter_if.sv | 28 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/cdb_arbiter.sv | 117 +++++++++++
 tb/tb_cdb_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_types.sv
// Shared core types.
// Holds the CDB broadcast record seen by the reservation stations, the ROB and
// the register file, and the index of the load/store unit on the CDB request
// vector. Synthesis option used elsewhere: CDB_LOAD_PRIO_EN.
package rv32i_types;

  localparam int CDB_TAG_W   = 4;
  localparam int CDB_DATA_W  = 32;
  localparam int EXU_LSU_IDX = 0;

  typedef struct packed {
    logic                  vld;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] wdata;
  } cdb_bcast_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Execution-unit -> CDB handshake bundle.
//   exu_req/exu_tag/exu_wdata : per-unit result, driven by the execution units
//   exu_rdy                   : per-unit grant, driven by the arbiter
//   cdb_vld/cdb_tag/cdb_wdata : registered broadcast, driven by the arbiter
// master = execution-unit side, slave = arbiter side.
interface cdb_arbiter_if #(
  parameter int N_EXU  = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
);
  logic [N_EXU-1:0]        exu_req;
  logic [N_EXU-1:0]        exu_rdy;
  logic [N_EXU*TAG_W-1:0]  exu_tag;
  logic [N_EXU*DATA_W-1:0] exu_wdata;
  logic                    cdb_vld;
  logic [TAG_W-1:0]        cdb_tag;
  logic [DATA_W-1:0]       cdb_wdata;

  modport master (
    output exu_req, exu_tag, exu_wdata,
    input  exu_rdy, cdb_vld, cdb_tag, cdb_wdata
  );

  modport slave (
    input  exu_req, exu_tag, exu_wdata,
    output exu_rdy, cdb_vld, cdb_tag, cdb_wdata
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   i_req     : request vector
//   i_ptr     : index that has highest priority this cycle (< N)
//   o_gnt     : one-hot grant (zero when no request)
//   o_gnt_idx : binary index of the granted bit
//   o_any     : any request granted
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [PTR_W-1:0] o_gnt_idx,
  output logic             o_any
);

  int               w_pos;
  logic [PTR_W-1:0] w_idx;

  // Scan i_ptr, i_ptr+1, ... wrapping at N; first set request wins.
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_any     = 1'b0;
    w_pos     = 0;
    w_idx     = '0;
    for (int i = 0; i < N; i++) begin
      w_pos = int'(i_ptr) + i;
      if (w_pos >= N) w_pos = w_pos - N;
      w_idx = PTR_W'(w_pos);
      if (!o_any && i_req[w_idx]) begin
        o_any        = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_gnt_idx    = w_idx;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: accepts one completed result per cycle from N_EXU
// execution units (round-robin) and broadcasts it on the registered CDB in the
// following cycle. The CDB is never back-pressured.
//   clk  : core clock
//   rst  : asynchronous reset, active low
//   bus  : cdb_arbiter_if.slave (unit requests/grants and CDB broadcast)
// Build option CDB_LOAD_PRIO_EN: unit 0 (LSU) always wins when requesting and
// does not move the round-robin pointer; the other units rotate among
// themselves. Without it all units are round-robin peers.
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int N_EXU  = 4,
  parameter int TAG_W  = CDB_TAG_W,
  parameter int DATA_W = CDB_DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  cdb_arbiter_if.slave  bus
);

  localparam int PTR_W = $clog2(N_EXU);

  // Same layout as rv32i_types::cdb_bcast_t, sized by this instance's parameters.
  typedef struct packed {
    logic              vld;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] wdata;
  } bcast_t;

  logic [PTR_W-1:0] r_rr_ptr;
  bcast_t           r_cdb;

  logic [N_EXU-1:0] w_rr_req;
  logic [N_EXU-1:0] w_rr_gnt;
  logic [PTR_W-1:0] w_rr_idx;
  logic             w_rr_any;
  logic [N_EXU-1:0] w_gnt;
  logic [PTR_W-1:0] w_gnt_idx;
  logic             w_any;
  logic             w_adv_ptr;
  logic [PTR_W-1:0] w_ptr_nxt;

  rr_arbiter #(.N(N_EXU), .PTR_W(PTR_W)) u_rr (
    .i_req     (w_rr_req),
    .i_ptr     (r_rr_ptr),
    .o_gnt     (w_rr_gnt),
    .o_gnt_idx (w_rr_idx),
    .o_any     (w_rr_any)
  );

`ifdef CDB_LOAD_PRIO_EN
  // The LSU is hidden from the rotation and overrides it when requesting.
  always_comb begin
    w_rr_req              = bus.exu_req;
    w_rr_req[EXU_LSU_IDX] = 1'b0;
  end

  always_comb begin
    w_gnt     = w_rr_gnt;
    w_gnt_idx = w_rr_idx;
    w_any     = w_rr_any;
    w_adv_ptr = w_rr_any;
    if (bus.exu_req[EXU_LSU_IDX]) begin
      w_gnt              = '0;
      w_gnt[EXU_LSU_IDX] = 1'b1;
      w_gnt_idx          = PTR_W'(EXU_LSU_IDX);
      w_any              = 1'b1;
      w_adv_ptr          = 1'b0;
    end
  end
`else
  assign w_rr_req  = bus.exu_req;
  assign w_gnt     = w_rr_gnt;
  assign w_gnt_idx = w_rr_idx;
  assign w_any     = w_rr_any;
  assign w_adv_ptr = w_rr_any;
`endif

  assign w_ptr_nxt = (w_gnt_idx == PTR_W'(N_EXU - 1)) ? '0 : w_gnt_idx + 1'b1;

  // Grants are combinational but must read zero while reset is held.
  assign bus.exu_rdy = rst ? w_gnt : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cdb    <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_cdb.vld <= w_any;
      if (w_any) begin
        r_cdb.tag   <= bus.exu_tag[w_gnt_idx*TAG_W +: TAG_W];
        r_cdb.wdata <= bus.exu_wdata[w_gnt_idx*DATA_W +: DATA_W];
      end
      if (w_adv_ptr) r_rr_ptr <= w_ptr_nxt;
    end
  end

  assign bus.cdb_vld   = r_cdb.vld;
  assign bus.cdb_tag   = r_cdb.tag;
  assign bus.cdb_wdata = r_cdb.wdata;

  a_rdy_onehot : assert property (@(posedge clk) disable iff (!rst)
    $onehot0(bus.exu_rdy));

  a_rdy_needs_req : assert property (@(posedge clk) disable iff (!rst)
    (bus.exu_rdy & ~bus.exu_req) == '0);

  for (genvar g = 0; g < N_EXU; g++) begin : g_stab
    a_req_stable : assert property (@(posedge clk) disable iff (!rst)
      (bus.exu_req[g] && !bus.exu_rdy[g]) |=>
        (bus.exu_req[g]
         && $stable(bus.exu_tag[g*TAG_W +: TAG_W])
         && $stable(bus.exu_wdata[g*DATA_W +: DATA_W])));
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.N_EXU(4), .TAG_W(4), .DATA_W(32)) bus ();

  cdb_arbiter #(.N_EXU(4), .TAG_W(4), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_unit(input int u, input logic [3:0] t, input logic [31:0] d);
    bus.exu_tag[u*4 +: 4]    = t;
    bus.exu_wdata[u*32 +: 32] = d;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) set_unit(i, 4'(8 + i), 32'hA000_0000 + 32'(i));
    bus.exu_req = 4'b1111;
    #1;
    vectors++;
    if (bus.exu_rdy !== 4'b0000) begin
      miscompares++; $display("FAIL reset_rdy: got %b want 0000", bus.exu_rdy);
    end
    vectors++;
    if (bus.cdb_vld !== 1'b0) begin
      miscompares++; $display("FAIL reset_vld: got %b want 0", bus.cdb_vld);
    end
    vectors++;
    if (bus.cdb_tag !== 4'h0) begin
      miscompares++; $display("FAIL reset_tag: got %h want 0", bus.cdb_tag);
    end
    vectors++;
    if (bus.cdb_wdata !== 32'h0) begin
      miscompares++; $display("FAIL reset_wdata: got %h want 0", bus.cdb_wdata);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.exu_rdy !== 4'b0001) begin
      miscompares++; $display("FAIL reset_first_gnt: got %b want 0001", bus.exu_rdy);
    end
    step();
    bus.exu_req = 4'b1110;
    vectors++;
    if (bus.cdb_vld !== 1'b1 || bus.cdb_tag !== 4'h8 || bus.cdb_wdata !== 32'hA000_0000) begin
      miscompares++;
      $display("FAIL reset_bcast0: got vld=%b tag=%h data=%h want 1/8/a0000000",
               bus.cdb_vld, bus.cdb_tag, bus.cdb_wdata);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.cdb_vld !== 1'b0 || bus.cdb_tag !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_mid_bcast: got vld=%b tag=%h want 0/0", bus.cdb_vld, bus.cdb_tag);
    end
    vectors++;
    if (bus.exu_rdy !== 4'b0000) begin
      miscompares++; $display("FAIL reset_mid_rdy: got %b want 0000", bus.exu_rdy);
    end
    step();
    bus.exu_req = 4'b0000;
    step();
    rst = 1'b1;
    bus.exu_req = 4'b1010;
    set_unit(1, 4'h1, 32'h1111_1111);
    set_unit(3, 4'h3, 32'h3333_3333);
    #1;
    vectors++;
    if (bus.exu_rdy !== 4'b0010) begin
      miscompares++; $display("FAIL reset_regrant: got %b want 0010", bus.exu_rdy);
    end
    step();
    vectors++;
    if (bus.cdb_vld !== 1'b1 || bus.cdb_tag !== 4'h1) begin
      miscompares++;
      $display("FAIL reset_bcast1: got vld=%b tag=%h want 1/1", bus.cdb_vld, bus.cdb_tag);
    end
    bus.exu_req = 4'b1000;
    #1;
    vectors++;
    if (bus.exu_rdy !== 4'b1000) begin
      miscompares++; $display("FAIL reset_next_gnt: got %b want 1000", bus.exu_rdy);
    end
    step();
    vectors++;
    if (bus.cdb_tag !== 4'h3 || bus.cdb_wdata !== 32'h3333_3333) begin
      miscompares++;
      $display("FAIL reset_bcast3: got tag=%h data=%h want 3/33333333", bus.cdb_tag, bus.cdb_wdata);
    end
    bus.exu_req = 4'b0000;
    step();
    vectors++;
    if (bus.cdb_vld !== 1'b0 || bus.cdb_tag !== 4'h3) begin
      miscompares++;
      $display("FAIL reset_idle_hold: got vld=%b tag=%h want 0/3", bus.cdb_vld, bus.cdb_tag);
    end
  endtask

  task automatic test_single();
    bus.exu_req = 4'b0100;
    set_unit(2, 4'h5, 32'hDEAD_BEEF);
    #1;
    vectors++;
    if (bus.exu_rdy !== 4'b0100) begin
      miscompares++; $display("FAIL single_rdy: got %b want 0100", bus.exu_rdy);
    end
    step();
    vectors++;
    if (bus.cdb_vld !== 1'b1 || bus.cdb_tag !== 4'h5 || bus.cdb_wdata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL single_bcast: got vld=%b tag=%h data=%h want 1/5/deadbeef",
               bus.cdb_vld, bus.cdb_tag, bus.cdb_wdata);
    end
    bus.exu_req = 4'b0000;
    #1;
    vectors++;
    if (bus.exu_rdy !== 4'b0000) begin
      miscompares++; $display("FAIL single_norq: got %b want 0000", bus.exu_rdy);
    end
    step();
    vectors++;
    if (bus.cdb_vld !== 1'b0 || bus.cdb_wdata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL single_after: got vld=%b data=%h want 0/deadbeef", bus.cdb_vld, bus.cdb_wdata);
    end
  endtask

  // Entered with rr_ptr=3.
  task automatic test_wrap();
    bus.exu_req = 4'b0101;
    set_unit(0, 4'hA, 32'h0000_000A);
    set_unit(2, 4'hC, 32'h0000_000C);
    #1;
    vectors++;
    if (bus.exu_rdy !== 4'b0001) begin
      miscompares++; $display("FAIL wrap_gnt0: got %b want 0001", bus.exu_rdy);
    end
    step();
    vectors++;
    if (bus.cdb_tag !== 4'hA) begin
      miscompares++; $display("FAIL wrap_bcast0: got %h want a", bus.cdb_tag);
    end
    bus.exu_req = 4'b0100;
    #1;
    vectors++;
    if (bus.exu_rdy !== 4'b0100) begin
      miscompares++; $display("FAIL wrap_gnt2: got %b want 0100", bus.exu_rdy);
    end
    step();
    vectors++;
    if (bus.cdb_vld !== 1'b1 || bus.cdb_tag !== 4'hC || bus.cdb_wdata !== 32'h0000_000C) begin
      miscompares++;
      $display("FAIL wrap_bcast2: got vld=%b tag=%h data=%h want 1/c/0000000c",
               bus.cdb_vld, bus.cdb_tag, bus.cdb_wdata);
    end
    bus.exu_req = 4'b0000;
    step();
  endtask

  // Entered with rr_ptr=3; unit 3 is used to bring it back to 0 first.
  task automatic test_back_to_back();
    logic [3:0] tags[4];
    int         rem[4];
    int         g;
    bus.exu_req = 4'b1000;
    set_unit(3, 4'hF, 32'h0);
    #1;
    vectors++;
    if (bus.exu_rdy !== 4'b1000) begin
      miscompares++; $display("FAIL b2b_setup: got %b want 1000", bus.exu_rdy);
    end
    step();
    for (int u = 0; u < 4; u++) begin
      rem[u]  = 2;
      tags[u] = 4'(u + 1);
      set_unit(u, tags[u], 32'hB000_0000 + 32'(u));
    end
    bus.exu_req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      g = k % 4;
      #1;
      vectors++;
      if (bus.exu_rdy !== 4'(1 << g)) begin
        miscompares++; $display("FAIL b2b_gnt k=%0d: got %b want %b", k, bus.exu_rdy, 4'(1 << g));
      end
      step();
      vectors++;
      if (bus.cdb_vld !== 1'b1 || bus.cdb_tag !== tags[g]) begin
        miscompares++;
        $display("FAIL b2b_bcast k=%0d: got vld=%b tag=%h want 1/%h", k, bus.cdb_vld, bus.cdb_tag, tags[g]);
      end
      rem[g]--;
      tags[g] = tags[g] + 4'h4;
      set_unit(g, tags[g], 32'hB000_0010 + 32'(g));
      bus.exu_req[g] = (rem[g] > 0);
    end
    step();
  endtask

  // Entered with rr_ptr=0.
  task automatic test_stability();
    logic [3:0] exp_rdy[3];
    logic [3:0] gnt;
    int         n_bcast = 0;
    int         gnt_cycle = -1;
    logic       data_ok = 1'b1;
    exp_rdy[0] = 4'b1000; exp_rdy[1] = 4'b0001; exp_rdy[2] = 4'b0010;
    bus.exu_req = 4'b0100;
    set_unit(2, 4'h2, 32'h2);
    step();
    bus.exu_req = 4'b0000;
    step();
    set_unit(0, 4'h0, 32'h0);
    set_unit(3, 4'h3, 32'h3);
    set_unit(1, 4'h7, 32'h7777_0001);
    bus.exu_req = 4'b1011;
    for (int c = 0; c < 5; c++) begin
      #1;
      gnt = bus.exu_rdy;
      if (c < 3) begin
        vectors++;
        if (gnt !== exp_rdy[c]) begin
          miscompares++; $display("FAIL stab_gnt c=%0d: got %b want %b", c, gnt, exp_rdy[c]);
        end
      end
      if (gnt[1]) gnt_cycle = c;
      step();
      if (bus.cdb_vld === 1'b1 && bus.cdb_tag === 4'h7) begin
        n_bcast++;
        if (bus.cdb_wdata !== 32'h7777_0001) data_ok = 1'b0;
      end
      bus.exu_req = bus.exu_req & ~gnt;
    end
    vectors++;
    if (gnt_cycle != 2) begin
      miscompares++; $display("FAIL stab_gnt_cycle: got %0d want 2", gnt_cycle);
    end
    vectors++;
    if (n_bcast != 1 || !data_ok) begin
      miscompares++; $display("FAIL stab_bcast_once: got count=%0d data_ok=%b want 1/1", n_bcast, data_ok);
    end
  endtask

`ifdef CDB_LOAD_PRIO_EN
  // Entered with rr_ptr=3; unit 3 is used to bring it back to 0 first.
  task automatic test_load_prio();
    bus.exu_req = 4'b1000;
    set_unit(3, 4'h3, 32'h3);
    step();
    bus.exu_req = 4'b0000;
    set_unit(0, 4'hA, 32'hA);
    set_unit(1, 4'h1, 32'h1);
    set_unit(2, 4'h2, 32'h2);
    bus.exu_req = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++;
      if (bus.exu_rdy !== 4'b0001) begin
        miscompares++; $display("FAIL prio_lsu c=%0d: got %b want 0001", c, bus.exu_rdy);
      end
      step();
      vectors++;
      if (bus.cdb_tag !== 4'hA) begin
        miscompares++; $display("FAIL prio_bcast c=%0d: got %h want a", c, bus.cdb_tag);
      end
    end
    bus.exu_req = 4'b1110;
    #1;
    vectors++;
    if (bus.exu_rdy !== 4'b0010) begin
      miscompares++; $display("FAIL prio_gnt1: got %b want 0010", bus.exu_rdy);
    end
    step();
    bus.exu_req = 4'b1100;
    #1;
    vectors++;
    if (bus.exu_rdy !== 4'b0100) begin
      miscompares++; $display("FAIL prio_gnt2: got %b want 0100", bus.exu_rdy);
    end
    step();
    bus.exu_req = 4'b1000;
    step();
    bus.exu_req = 4'b0000;
    step();
  endtask
`endif

  initial begin
    rst           = 1'b0;
    bus.exu_req   = '0;
    bus.exu_tag   = '0;
    bus.exu_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single();
`ifdef CDB_LOAD_PRIO_EN
    test_load_prio();
`else
    test_wrap();
    test_back_to_back();
    test_stability();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
